// File: rtl/vmem_pkg.sv
// Shared types for the vmem accumulate sequencer: FSM states, default sizes, command record.
package vmem_pkg;

  localparam int LEN_W_DEF      = 16;
  localparam int ELEM_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // The len field is sized by the package default, so a top-level LEN_W override must match it.
  typedef struct packed {
    logic [31:0]           base_a;
    logic [31:0]           base_b;
    logic [31:0]           base_c;
    logic [LEN_W_DEF-1:0]  len;
    logic [15:0]           stride;
  } cmd_t;

endpackage

// File: rtl/vmem_cmd_slot.sv
// One-entry command holding register: accepts when empty, emptied by the sequencer via clr.
module vmem_cmd_slot
  import vmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  cmd_t in_cmd,
  input  logic clr,
  output logic full,
  output cmd_t cmd
);

  assign in_ready = !full;

  // Accept and clear are mutually exclusive: accept needs an empty slot, clear a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      cmd  <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      cmd  <= in_cmd;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/vmem_acc_seq.sv
// Vector memory accumulate sequencer: streams C[i] += A[i] + B[i] through vmem, one element per cycle.
// Build option VMEM_STRIDE_EN adds a per-command byte stride port; otherwise stride is ELEM_BYTES.
//
// state   | meaning
// IDLE    | waiting for a command in the slot
// RUN     | one element read and written per cycle
// DONE    | single-cycle completion pulse
module vmem_acc_seq
  import vmem_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int ELEM_BYTES = ELEM_BYTES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_base_a,
  input  logic [31:0]      cmd_base_b,
  input  logic [31:0]      cmd_base_c,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef VMEM_STRIDE_EN
  input  logic [15:0]      cmd_stride,
`endif
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] elem_cnt,
  output logic [31:0]      vm_addr_a,
  output logic [31:0]      vm_addr_b,
  output logic [31:0]      vm_addr_c,
  output logic [31:0]      vm_wd,
  output logic             vm_we,
  input  logic [31:0]      vm_rv_a,
  input  logic [31:0]      vm_rv_b
);

  state_e           state, state_nxt;
  cmd_t             cmd_in, slot_cmd;
  logic             slot_full, slot_clr, load;
  logic [15:0]      stride_r;
  logic [LEN_W-1:0] remain;
  logic             run_active;

  assign cmd_in.base_a = cmd_base_a;
  assign cmd_in.base_b = cmd_base_b;
  assign cmd_in.base_c = cmd_base_c;
  assign cmd_in.len    = cmd_len;
`ifdef VMEM_STRIDE_EN
  assign cmd_in.stride = cmd_stride;
`else
  assign cmd_in.stride = 16'(ELEM_BYTES);
`endif

  vmem_cmd_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (cmd_valid),
    .in_ready (cmd_ready),
    .in_cmd   (cmd_in),
    .clr      (slot_clr),
    .full     (slot_full),
    .cmd      (slot_cmd)
  );

  always_comb begin
    state_nxt = state;
    slot_clr  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_full) begin
          slot_clr = 1'b1;
          if (slot_cmd.len != '0) begin
            load      = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (remain == LEN_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates the write enable combinationally so the aborting edge itself does not write.
  assign run_active = (state == ST_RUN) && !reset;
  assign vm_we      = run_active;
  assign vm_wd      = run_active ? (vm_rv_a + vm_rv_b) : 32'd0;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      vm_addr_a <= '0;
      vm_addr_b <= '0;
      vm_addr_c <= '0;
      stride_r  <= '0;
      remain    <= '0;
      elem_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        vm_addr_a <= slot_cmd.base_a;
        vm_addr_b <= slot_cmd.base_b;
        vm_addr_c <= slot_cmd.base_c;
        stride_r  <= slot_cmd.stride;
        remain    <= slot_cmd.len;
        elem_cnt  <= '0;
      end else if (state == ST_RUN) begin
        vm_addr_a <= vm_addr_a + {16'd0, stride_r};
        vm_addr_b <= vm_addr_b + {16'd0, stride_r};
        vm_addr_c <= vm_addr_c + {16'd0, stride_r};
        remain    <= remain - LEN_W'(1);
        elem_cnt  <= elem_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vmem_acc_seq.sv
// Self-checking bench for vmem_acc_seq with a behavioural word memory standing in for vmem.
module tb_vmem_acc_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base_a = '0, cmd_base_b = '0, cmd_base_c = '0;
  logic [15:0] cmd_len = '0;
`ifdef VMEM_STRIDE_EN
  logic [15:0] cmd_stride = 16'd4;
`endif
  logic        busy, done, vm_we;
  logic [15:0] elem_cnt;
  logic [31:0] vm_addr_a, vm_addr_b, vm_addr_c, vm_wd, vm_rv_a, vm_rv_b;

  vmem_acc_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_base_c(cmd_base_c), .cmd_len(cmd_len),
`ifdef VMEM_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .busy(busy), .done(done), .elem_cnt(elem_cnt),
    .vm_addr_a(vm_addr_a), .vm_addr_b(vm_addr_b), .vm_addr_c(vm_addr_c),
    .vm_wd(vm_wd), .vm_we(vm_we), .vm_rv_a(vm_rv_a), .vm_rv_b(vm_rv_b)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign vm_rv_a = mem[vm_addr_a[11:2]];
  assign vm_rv_b = mem[vm_addr_b[11:2]];

  int cyc = 0, we_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int we_cyc_q[$], hs_cyc_q[$], done_cyc_q[$];
  logic [31:0] wa_q[$], wc_q[$], wd_q[$];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (vm_we) begin
      mem[vm_addr_c[11:2]] <= mem[vm_addr_c[11:2]] + vm_wd;
      we_cnt <= we_cnt + 1;
      we_cyc_q.push_back(cyc);
      wa_q.push_back(vm_addr_a);
      wc_q.push_back(vm_addr_c);
      wd_q.push_back(vm_wd);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc_q.push_back(cyc);
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (cmd_valid && cmd_ready) hs_cyc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  // All tasks start and end just after a negedge.
  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a[11:2]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [15:0] n, input logic [15:0] s);
    int k;
    cmd_base_a = a; cmd_base_b = b; cmd_base_c = c; cmd_len = n; cmd_valid = 1'b1;
`ifdef VMEM_STRIDE_EN
    cmd_stride = s;
`else
    if (s != 16'd4) $display("note: stride %0d ignored in fixed-stride build", s);
`endif
    k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_cnt <= base && k < 300) begin @(negedge clk); k++; end
    if (done_cnt <= base) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, base + 1);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c0;
    logic [31:0] exp_c;
  } elem_vec_t;

  elem_vec_t t1[4];
  elem_vec_t t3[5];
  int wb, db, bb, hb, qb;

  initial begin
    t1[0] = '{32'd1, 32'd10, 32'd5, 32'd16};
    t1[1] = '{32'd2, 32'd20, 32'd5, 32'd27};
    t1[2] = '{32'd3, 32'd30, 32'd5, 32'd38};
    t1[3] = '{32'd4, 32'd40, 32'd5, 32'd49};
    // first three: job 1 (C@0x480 from 0), last two: job 2 reuses A/B, C@0x4C0 from 7
    t3[0] = '{32'd1, 32'd100, 32'd0, 32'd101};
    t3[1] = '{32'd2, 32'd200, 32'd0, 32'd202};
    t3[2] = '{32'd3, 32'd300, 32'd0, 32'd303};
    t3[3] = '{32'd1, 32'd100, 32'd7, 32'd108};
    t3[4] = '{32'd2, 32'd200, 32'd7, 32'd209};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_elem_cnt",  {16'd0, elem_cnt},  32'd0);
    chk("rst_we",        {31'd0, vm_we},     32'd0);
    chk("rst_addr_c",    vm_addr_c,          32'd0);

    // job of four elements, fixed latency checks
    for (int i = 0; i < 4; i++) begin
      poke(32'h000 + 4*i, t1[i].a);
      poke(32'h100 + 4*i, t1[i].b);
      poke(32'h200 + 4*i, t1[i].c0);
    end
    wb = we_cnt; db = done_cnt; qb = we_cyc_q.size(); hb = hs_cyc_q.size();
    send(32'h000, 32'h100, 32'h200, 16'd4, 16'd4);
    wait_done(db);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("j1_c%0d", i), peek(32'h200 + 4*i), t1[i].exp_c);
    chk("j1_we_count",   32'(we_cnt - wb), 32'd4);
    chk("j1_done_count", 32'(done_cnt - db), 32'd1);
    chk("j1_first_wr",   32'(we_cyc_q[qb] - hs_cyc_q[hb]), 32'd2);
    chk("j1_last_wr",    32'(we_cyc_q[qb+3] - hs_cyc_q[hb]), 32'd5);
    chk("j1_done_cyc",   32'(done_cyc_q[db] - hs_cyc_q[hb]), 32'd6);

    // zero-length job
    wb = we_cnt; db = done_cnt; bb = busy_cnt; hb = hs_cyc_q.size();
    send(32'h040, 32'h140, 32'h240, 16'd0, 16'd4);
    wait_done(db);
    repeat (3) @(negedge clk);
    chk("n0_we_count",  32'(we_cnt - wb), 32'd0);
    chk("n0_done_cyc",  32'(done_cyc_q[db] - hs_cyc_q[hb]), 32'd2);
    chk("n0_busy_cyc",  32'(busy_cnt - bb), 32'd1);

    // back-to-back: second command offered while the first runs
    for (int i = 0; i < 3; i++) begin
      poke(32'h400 + 4*i, t3[i].a);
      poke(32'h440 + 4*i, t3[i].b);
      poke(32'h480 + 4*i, t3[i].c0);
    end
    for (int i = 0; i < 2; i++) poke(32'h4C0 + 4*i, t3[3+i].c0);
    wb = we_cnt; db = done_cnt; qb = we_cyc_q.size(); hb = hs_cyc_q.size();
    send(32'h400, 32'h440, 32'h480, 16'd3, 16'd4);
    chk("b2b_ready_slot_full", {31'd0, cmd_ready}, 32'd0);
    send(32'h400, 32'h440, 32'h4C0, 16'd2, 16'd4);
    chk("b2b_ready_while_run", {31'd0, cmd_ready}, 32'd0);
    chk("b2b_busy_while_run",  {31'd0, busy},      32'd1);
    wait_done(db);
    wait_done(db + 1);
    repeat (2) @(negedge clk);
    chk("b2b_hs_gap",    32'(hs_cyc_q[hb+1] - hs_cyc_q[hb]), 32'd2);
    chk("b2b_wr_gap",    32'(we_cyc_q[qb+3] - we_cyc_q[qb]), 32'd5);
    chk("b2b_we_count",  32'(we_cnt - wb), 32'd5);
    chk("b2b_ready_end", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_j1_c%0d", i), peek(32'h480 + 4*i), t3[i].exp_c);
    for (int i = 0; i < 2; i++) chk($sformatf("b2b_j2_c%0d", i), peek(32'h4C0 + 4*i), t3[3+i].exp_c);

    // carry drop and address wrap
    poke(32'h300, 32'hFFFF_FFFF); poke(32'h304, 32'd5);
    poke(32'h380, 32'd2);         poke(32'h384, 32'd7);
    poke(32'hFFFF_FFFC, 32'd0);   poke(32'h000, 32'd100);
    db = done_cnt; qb = wd_q.size();
    send(32'h300, 32'h380, 32'hFFFF_FFFC, 16'd2, 16'd4);
    wait_done(db);
    repeat (2) @(negedge clk);
    chk("wrap_wd0",    wd_q[qb],   32'h0000_0001);
    chk("wrap_addr1",  wc_q[qb+1], 32'h0000_0000);
    chk("wrap_c_top",  peek(32'hFFFF_FFFC), 32'd1);
    chk("wrap_c_zero", peek(32'h000), 32'd112);

    // reset in the second RUN cycle of an 8-element job, with a command pending
    for (int i = 0; i < 8; i++) begin
      poke(32'h500 + 4*i, 32'd3);
      poke(32'h540 + 4*i, 32'd4);
      poke(32'h580 + 4*i, 32'd0);
    end
    poke(32'h600, 32'd0);
    wb = we_cnt; db = done_cnt; hb = hs_cyc_q.size();
    send(32'h500, 32'h540, 32'h580, 16'd8, 16'd4);
    cmd_base_a = 32'h500; cmd_base_b = 32'h540; cmd_base_c = 32'h600; cmd_len = 16'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hs_count", 32'(hs_cyc_q.size() - hb), 32'd2);
    chk("abort_we_now",   {31'd0, vm_we},     32'd0);
    chk("abort_ready",    {31'd0, cmd_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("abort_we_count",   32'(we_cnt - wb),   32'd1);
    chk("abort_done_count", 32'(done_cnt - db), 32'd0);
    chk("abort_busy",       {31'd0, busy},      32'd0);
    chk("abort_c0",         peek(32'h580), 32'd7);
    chk("abort_c1",         peek(32'h584), 32'd0);
    chk("abort_pending_c",  peek(32'h600), 32'd0);

`ifdef VMEM_STRIDE_EN
    qb = wa_q.size(); db = done_cnt;
    send(32'h700, 32'h780, 32'h7C0, 16'd3, 16'd8);
    wait_done(db);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stride_a%0d", i), wa_q[qb+i], 32'h700 + 32'(8*i));
      chk($sformatf("stride_c%0d", i), wc_q[qb+i], 32'h7C0 + 32'(8*i));
    end
    poke(32'h800, 32'd1); poke(32'h840, 32'd1); poke(32'h880, 32'd0);
    db = done_cnt;
    send(32'h800, 32'h840, 32'h880, 16'd3, 16'd0);
    wait_done(db);
    repeat (2) @(negedge clk);
    chk("stride0_accum", peek(32'h880), 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
